gelux_stream_ctrl: RTL

//  Ready/valid front-end and back-end for the fixed-latency gelux FP32 GELU core.
//  - Accepts FP32 operands on an input stream and issues them into the core.
//  - Overrides the core result for IEEE special inputs (NaN/Inf/zero/denormal).
//  - Buffers core results in a credit-checked FIFO, so downstream backpressure never drops a result.

---
 rtl/gelux_stream_ctrl_pkg.sv | 56 +++++
 rtl/gelux_stream_ctrl_if.sv | 39 +++
 rtl/gelux_stream_ctrl_sync_fifo.sv | 67 ++++++
 rtl/gelux_stream_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/gelux_stream_ctrl_pkg.sv
// Shared types, FP32 constants and field helpers for the gelux stream controller.
// The core result is replaced for IEEE special inputs, so each operand is classified on issue.
package gelux_stream_ctrl_pkg;

  localparam int unsigned Fp32W = 32;

  typedef enum logic [2:0] {
    ClsNorm,
    ClsNan,
    ClsPinf,
    ClsNinf,
    ClsZero
  } cls_e;

  localparam logic [Fp32W-1:0] FpQnan  = 32'h7FC0_0000;
  localparam logic [Fp32W-1:0] FpPinf  = 32'h7F80_0000;
  localparam logic [Fp32W-1:0] FpPzero = 32'h0000_0000;

  // One sideband slot travels alongside each operand inside the core.
  typedef struct packed {
    logic v;
    logic last;
    cls_e cls;
  } sb_t;

  function automatic logic fp32_sign(input logic [Fp32W-1:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp32_exp(input logic [Fp32W-1:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp32_mant(input logic [Fp32W-1:0] x);
    return x[22:0];
  endfunction

  // Denormals are grouped with zero: GELU of a denormal is flushed to +0.
  function automatic cls_e fp32_classify(input logic [Fp32W-1:0] x);
    cls_e cls;
    cls = ClsNorm;
    if (fp32_exp(x) == 8'hFF) begin
      if (fp32_mant(x) != 23'd0) begin
        cls = ClsNan;
      end else if (fp32_sign(x)) begin
        cls = ClsNinf;
      end else begin
        cls = ClsPinf;
      end
    end else if (fp32_exp(x) == 8'h00) begin
      cls = ClsZero;
    end
    return cls;
  endfunction

endpackage

// File: rtl/gelux_stream_ctrl_if.sv
// Ready/valid operand input stream and result output stream of the gelux controller.
// The slave modport is the controller's view; the master modport is the surrounding system's.
interface gelux_stream_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/gelux_stream_ctrl_sync_fifo.sv
// Synchronous FIFO with occupancy count; the head word is driven as 0 while empty.
// Pushing into a full FIFO is a protocol violation and is flagged by an assertion.
module gelux_stream_ctrl_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty, full, do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(DEPTH));
  assign do_pop = pop_i & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty ? '0 : mem_q[rptr_q];
  assign empty_o = empty;
  assign count_o = count_q;

  push_while_full_a : assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/gelux_stream_ctrl.sv
// Ready/valid wrapper around the fixed-latency gelux FP32 GELU core: credit-based issue,
// special-value override on retire and a result FIFO that absorbs downstream backpressure.
module gelux_stream_ctrl
  import gelux_stream_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CORE_LAT   = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  gelux_stream_ctrl_if.slave     strm_io,
  output logic                   core_en,
  output logic                   core_vld_in,
  output logic [DATA_WIDTH-1:0]  core_operand,
  input  logic [DATA_WIDTH-1:0]  core_result,
  input  logic                   core_vld_out,
  output logic                   busy,
  output logic                   seq_err,
  output logic [CNT_WIDTH-1:0]   elem_cnt
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  sb_t [CORE_LAT-1:0]    sb_q, sb_d;
  sb_t                   sb_in, sb_tail;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [CntW-1:0]       fifo_cnt;
  logic [CntW:0]         credits_used;
  logic                  in_ready, issue, retire;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  fifo_empty, pop;
  logic                  seq_err_q, seq_err_d;
  logic [CNT_WIDTH-1:0]  elem_cnt_q, elem_cnt_d;

  // Credits count every result that could still land in the FIFO, so a retire never
  // finds it full. Only registers feed in_ready; in_valid has no path to it.
  assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign in_ready     = ~rst & (credits_used < (CntW + 1)'(FIFO_DEPTH));
  assign issue        = strm_io.in_valid & in_ready;

  assign strm_io.in_ready = in_ready;
  assign core_en          = ~rst;
  assign core_vld_in      = issue;
  assign core_operand     = strm_io.in_data;

  always_comb begin
    sb_in      = '0;
    sb_in.v    = issue;
    sb_in.last = strm_io.in_last;
    sb_in.cls  = fp32_classify(strm_io.in_data);
    sb_d       = {sb_q[CORE_LAT-2:0], sb_in};
  end

  assign sb_tail = sb_q[CORE_LAT-1];
  assign retire  = sb_tail.v;

  always_comb begin
    result = core_result;
    case (sb_tail.cls)
      ClsNan:           result = FpQnan;
      ClsPinf:          result = FpPinf;
      ClsNinf, ClsZero: result = FpPzero;
      default:          result = core_result;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q + CntW'(issue) - CntW'(retire);
    // Any disagreement between our sideband and the core's strobe is latched for software.
    seq_err_d  = seq_err_q | (sb_tail.v != core_vld_out);
    elem_cnt_d = elem_cnt_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q       <= '0;
      inflight_q <= '0;
      seq_err_q  <= 1'b0;
      elem_cnt_q <= '0;
    end else begin
      sb_q       <= sb_d;
      inflight_q <= inflight_d;
      seq_err_q  <= seq_err_d;
      elem_cnt_q <= elem_cnt_d;
    end
  end

  gelux_stream_ctrl_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (retire),
    .wdata_i ({sb_tail.last, result}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign pop               = ~fifo_empty & strm_io.out_ready;
  assign strm_io.out_valid = ~fifo_empty;
  assign strm_io.out_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign strm_io.out_last  = fifo_rdata[DATA_WIDTH];

  assign busy     = (inflight_q != '0) | ~fifo_empty;
  assign seq_err  = seq_err_q;
  assign elem_cnt = elem_cnt_q;

endmodule
